// File: rtl/fetch.sv
// ---------------------------------------------------------------------------
// fetch -- instruction-fetch stage of the five-stage RV64 pipeline.
//
// Owns the program counter and keeps at most one instruction-bus read in
// flight. Fetched words are presented to decode through the registered
// dataF bundle. Decode can stall the stage or redirect it for one cycle.
// Wrong-path words are squashed, including a response that is still
// outstanding on the bus when the redirect arrives.
//
// Ports
//   clk, reset       clock, asynchronous active-high reset
//   ireq_valid       read request, held until iresp_data_ok
//   ireq_addr        request address, stable while ireq_valid is high
//   iresp_data_ok    response strobe, completes the request
//   iresp_data       instruction word, valid with iresp_data_ok
//   stall            decode cannot accept; dataF holds
//   redirect_valid   one-cycle redirect from decode (ignored while stalled)
//   redirect_pc      redirect target
//   dataF            registered {raw_instr, pc, is_bubble} to decode
// ---------------------------------------------------------------------------
package fetch_pkg;
   typedef struct packed {
      logic [31:0] raw_instr;
      logic [63:0] pc;
      logic        is_bubble;
   } fetch_data_t;

   localparam fetch_data_t FETCH_BUBBLE = '{raw_instr: 32'h0, pc: 64'h0, is_bubble: 1'b1};
endpackage

module fetch
   import fetch_pkg::*;
#(
   parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        ireq_valid,
   output logic [63:0] ireq_addr,
   input  logic        iresp_data_ok,
   input  logic [31:0] iresp_data,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_pc,
   output fetch_data_t dataF
);

   typedef enum logic [1:0] {IDLE, REQ, HOLD, DISCARD} state_t;

   state_t      state, state_n;
   logic [63:0] fetch_pc, fetch_pc_n;
   logic [31:0] buf_instr, buf_instr_n;
   logic [63:0] buf_pc, buf_pc_n;
   logic [63:0] pend_pc, pend_pc_n;
   fetch_data_t data_n;
   logic        take_redirect;

   // A redirect raised during a stall is dropped; decode re-asserts it.
   assign take_redirect = redirect_valid & ~stall;

   // DISCARD keeps the wrong-path request alive so the bus handshake completes.
   assign ireq_valid = (state == REQ) || (state == DISCARD);
   assign ireq_addr  = fetch_pc;

   always_comb begin
      state_n     = state;
      fetch_pc_n  = fetch_pc;
      buf_instr_n = buf_instr;
      buf_pc_n    = buf_pc;
      pend_pc_n   = pend_pc;
      data_n      = dataF;

      case (state)
         IDLE: state_n = REQ;

         REQ: begin
            if (iresp_data_ok) begin
               if (take_redirect) begin
                  // Redirect beats the arriving word.
                  fetch_pc_n = redirect_pc;
                  data_n     = FETCH_BUBBLE;
               end else if (!stall) begin
                  data_n     = '{raw_instr: iresp_data, pc: fetch_pc, is_bubble: 1'b0};
                  fetch_pc_n = fetch_pc + 64'd4;
               end else begin
                  // Decode is full: park the word rather than lose it.
                  buf_instr_n = iresp_data;
                  buf_pc_n    = fetch_pc;
                  fetch_pc_n  = fetch_pc + 64'd4;
                  state_n     = HOLD;
               end
            end else begin
               if (take_redirect) begin
                  pend_pc_n = redirect_pc;
                  data_n    = FETCH_BUBBLE;
                  state_n   = DISCARD;
               end else if (!stall) begin
                  data_n = FETCH_BUBBLE;
               end
            end
         end

         HOLD: begin
            if (!stall) begin
               if (take_redirect) begin
                  fetch_pc_n = redirect_pc;
                  data_n     = FETCH_BUBBLE;
               end else begin
                  data_n = '{raw_instr: buf_instr, pc: buf_pc, is_bubble: 1'b0};
               end
               state_n = REQ;
            end
         end

         DISCARD: begin
            if (!stall) data_n = FETCH_BUBBLE;
            if (take_redirect) pend_pc_n = redirect_pc;
            if (iresp_data_ok) begin
               // Newest redirect target wins if one lands on the response cycle.
               fetch_pc_n = take_redirect ? redirect_pc : pend_pc;
               state_n    = REQ;
            end
         end

         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         fetch_pc  <= RESET_PC;
         buf_instr <= 32'h0;
         buf_pc    <= 64'h0;
         pend_pc   <= 64'h0;
         dataF     <= FETCH_BUBBLE;
      end else begin
         state     <= state_n;
         fetch_pc  <= fetch_pc_n;
         buf_instr <= buf_instr_n;
         buf_pc    <= buf_pc_n;
         pend_pc   <= pend_pc_n;
         dataF     <= data_n;
      end
   end

endmodule

// File: tb/tb_fetch.sv
// ---------------------------------------------------------------------------
// tb_fetch -- self-checking bench for fetch.
//
// A bus agent answers requests after 1..4 cycles with a word derived from the
// address. A transaction-level model tracks the next correct-path pc, whether
// the outstanding read is wrong-path, and whether a word is parked during a
// stall, and from that predicts dataF every cycle. A second instance with a
// reset pc near the top of the address space checks pc wrap-around.
// ---------------------------------------------------------------------------
module tb_fetch;
   import fetch_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        ireq_valid;
   logic [63:0] ireq_addr;
   logic        iresp_data_ok;
   logic [31:0] iresp_data;
   logic        stall;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   fetch_data_t dataF;

   logic        ireq_valid_w;
   logic [63:0] ireq_addr_w;
   logic        iresp_data_ok_w;
   logic [31:0] iresp_data_w;
   logic        stall_w = 1'b0;
   logic        redirect_valid_w = 1'b0;
   logic [63:0] redirect_pc_w = 64'h0;
   fetch_data_t dataF_w;

   always #5 clk = ~clk;

   fetch dut (
      .clk(clk), .reset(reset),
      .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
      .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
      .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .dataF(dataF)
   );

   fetch #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFF8)) dut_w (
      .clk(clk), .reset(reset),
      .ireq_valid(ireq_valid_w), .ireq_addr(ireq_addr_w),
      .iresp_data_ok(iresp_data_ok_w), .iresp_data(iresp_data_w),
      .stall(stall_w), .redirect_valid(redirect_valid_w), .redirect_pc(redirect_pc_w),
      .dataF(dataF_w)
   );

   function automatic logic [31:0] ins_of(input logic [63:0] a);
      return a[31:0] ^ a[63:32] ^ 32'h1357_9BDF;
   endfunction

   function automatic fetch_data_t word_at(input logic [63:0] p);
      return '{raw_instr: ins_of(p), pc: p, is_bubble: 1'b0};
   endfunction

   // zero-wait memory for the wrap-around instance
   assign iresp_data_ok_w = ireq_valid_w;
   assign iresp_data_w    = ins_of(ireq_addr_w);

   int checks = 0;
   int errors = 0;

   // bus agent
   bit          busy;
   int          cnt, lat, fixed_lat;
   // reference model
   logic [63:0] exp_pc;
   bit          wrong, held;
   logic [63:0] held_pc;
   int          delivered;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      stall          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 64'h0;
      iresp_data_ok  = 1'b0;
      iresp_data     = 32'h0;
      reset          = 1'b1;
      #1;
      chk("rst_dataF", 128'(dataF), 128'(FETCH_BUBBLE));
      chk("rst_valid", 128'(ireq_valid), 128'(1'b0));
      @(negedge clk);
      @(negedge clk);
      reset  = 1'b0;
      busy   = 1'b0;
      wrong  = 1'b0;
      held   = 1'b0;
      exp_pc = 64'h0000_0000_8000_0000;
   endtask

   // One clock cycle: called at a falling edge with stall/redirect already set.
   task automatic step();
      logic        pv, dok, st, hon, deliver;
      logic [63:0] pa, rpc, p;
      fetch_data_t pd, exp_d;

      if (ireq_valid) begin
         if (!busy) begin
            busy = 1'b1;
            cnt  = 0;
            lat  = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 4));
         end
         dok = (cnt == lat - 1);
      end else begin
         dok = 1'b0;
      end
      iresp_data_ok = dok;
      iresp_data    = dok ? ins_of(ireq_addr) : $urandom;

      pv  = ireq_valid;
      pa  = ireq_addr;
      pd  = dataF;
      st  = stall;
      hon = redirect_valid & ~stall;
      rpc = redirect_pc;

      @(posedge clk);
      #1;
      if (dok) busy = 1'b0;
      else if (pv) cnt++;

      deliver = 1'b0;
      p       = 64'h0;
      if (st) begin
         exp_d = pd;
         if (pv && dok) begin
            if (wrong) wrong = 1'b0;
            else begin
               held    = 1'b1;
               held_pc = pa;
            end
         end
      end else begin
         if (held) begin
            if (!hon) begin
               deliver = 1'b1;
               p       = held_pc;
            end
            held = 1'b0;
         end else if (pv && dok && !wrong && !hon) begin
            deliver = 1'b1;
            p       = pa;
         end
         if (pv && dok) wrong = 1'b0;
         if (hon) begin
            if (pv && !dok) wrong = 1'b1;
            exp_pc = rpc;
         end
         exp_d = deliver ? word_at(p) : FETCH_BUBBLE;
         if (deliver) begin
            chk("deliver_pc", 128'(p), 128'(exp_pc));
            exp_pc = p + 64'd4;
            delivered++;
         end
      end
      chk("dataF", 128'(dataF), 128'(exp_d));
      if (pv && !dok) chk("req_stable", 128'({ireq_valid, ireq_addr}), 128'({1'b1, pa}));
      if (held) chk("hold_noreq", 128'(ireq_valid), 128'(1'b0));
      @(negedge clk);
   endtask

   function automatic logic [63:0] pick_target();
      logic [63:0] t;
      case ($urandom_range(0, 2))
         0:       t = 64'h8000_0000 + 64'({$urandom_range(0, 1023), 2'b00});
         1:       t = {$urandom, $urandom};
         default: t = 64'hFFFF_FFFF_FFFF_FFF0 + 64'({$urandom_range(0, 3), 2'b00});
      endcase
      return t;
   endfunction

   initial begin
      reset = 1'b0;
      fixed_lat = 1;
      delivered = 0;
      #2;

      // zero-wait memory, plus the wrap-around instance
      do_reset();
      fixed_lat = 1;
      step();
      chk("d1_a0", 128'({ireq_valid, ireq_addr}), 128'({1'b1, 64'h8000_0000}));
      chk("w_a0", 128'({ireq_valid_w, ireq_addr_w}), 128'({1'b1, 64'hFFFF_FFFF_FFFF_FFF8}));
      step();
      chk("d1_a1", 128'(ireq_addr), 128'(64'h8000_0004));
      chk("d1_pc0", 128'({dataF.pc, dataF.is_bubble}), 128'({64'h8000_0000, 1'b0}));
      chk("w_a1", 128'(ireq_addr_w), 128'(64'hFFFF_FFFF_FFFF_FFFC));
      step();
      chk("d1_a2", 128'(ireq_addr), 128'(64'h8000_0008));
      chk("d1_pc1", 128'({dataF.pc, dataF.is_bubble}), 128'({64'h8000_0004, 1'b0}));
      chk("w_a2", 128'({ireq_valid_w, ireq_addr_w}), 128'({1'b1, 64'h0}));
      chk("w_pc1", 128'(dataF_w), 128'(word_at(64'hFFFF_FFFF_FFFF_FFFC)));

      // 3-cycle memory
      do_reset();
      fixed_lat = 3;
      step();
      chk("d2_addr0", 128'(ireq_addr), 128'(64'h8000_0000));
      step();
      chk("d2_addr1", 128'(ireq_addr), 128'(64'h8000_0000));
      chk("d2_bub1", 128'(dataF), 128'(FETCH_BUBBLE));
      step();
      chk("d2_addr2", 128'(ireq_addr), 128'(64'h8000_0000));
      chk("d2_bub2", 128'(dataF), 128'(FETCH_BUBBLE));
      step();
      chk("d2_word", 128'(dataF), 128'(word_at(64'h8000_0000)));
      chk("d2_next", 128'({ireq_valid, ireq_addr}), 128'({1'b1, 64'h8000_0004}));

      // stall for 4 cycles starting on the response to 8000_0004
      do_reset();
      fixed_lat = 1;
      step();
      step();
      stall = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("d3_hold", 128'(dataF), 128'(word_at(64'h8000_0000)));
         chk("d3_noreq", 128'(ireq_valid), 128'(1'b0));
      end
      stall = 1'b0;
      step();
      chk("d3_rel", 128'(dataF), 128'(word_at(64'h8000_0004)));
      chk("d3_next", 128'({ireq_valid, ireq_addr}), 128'({1'b1, 64'h8000_0008}));

      // redirect while the read of 8000_0008 is in flight
      do_reset();
      fixed_lat = 1;
      step();
      step();
      step();
      fixed_lat      = 3;
      redirect_valid = 1'b1;
      redirect_pc    = 64'h8000_0100;
      step();
      redirect_valid = 1'b0;
      chk("d4_bub0", 128'(dataF), 128'(FETCH_BUBBLE));
      chk("d4_keep", 128'({ireq_valid, ireq_addr}), 128'({1'b1, 64'h8000_0008}));
      step();
      chk("d4_bub1", 128'(dataF), 128'(FETCH_BUBBLE));
      step();
      chk("d4_bub2", 128'(dataF), 128'(FETCH_BUBBLE));
      chk("d4_newreq", 128'({ireq_valid, ireq_addr}), 128'({1'b1, 64'h8000_0100}));
      fixed_lat = 1;
      step();
      chk("d4_word", 128'(dataF), 128'(word_at(64'h8000_0100)));

      // redirect under stall is ignored; re-asserted one drops the held word
      do_reset();
      fixed_lat = 1;
      step();
      step();
      stall          = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 64'h8000_0300;
      step();
      chk("d5_hold", 128'(dataF), 128'(word_at(64'h8000_0000)));
      step();
      chk("d5_noreq", 128'(ireq_valid), 128'(1'b0));
      stall       = 1'b0;
      redirect_pc = 64'h8000_0200;
      step();
      redirect_valid = 1'b0;
      chk("d5_drop", 128'(dataF), 128'(FETCH_BUBBLE));
      chk("d5_req", 128'({ireq_valid, ireq_addr}), 128'({1'b1, 64'h8000_0200}));
      step();
      chk("d5_word", 128'(dataF), 128'(word_at(64'h8000_0200)));

      // randomized traffic against the model, with one reset mid-run
      do_reset();
      fixed_lat = 0;
      delivered = 0;
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) do_reset();
         stall          = ($urandom_range(0, 99) < 30);
         redirect_valid = ($urandom_range(0, 99) < 10);
         redirect_pc    = pick_target();
         step();
      end
      chk("progress", 128'(delivered > 400), 128'(1'b1));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
